// File: rtl/net_force_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : net_force_arbiter
// Purpose  : Shares one WIDTH-bit overridable net among N requesters. Each
//            requester can force the net to its own value for a programmed
//            number of cycles. The block runs a FORCE phase, then a one-cycle
//            RELEASE phase, so only one override is active at a time. Grants
//            rotate round-robin. Between overrides the net shows the nominal
//            driver.
// Ports    : clk_i         rising-edge clock
//            reset_i       synchronous, active-high reset
//            nominal_i     value driven when no override is active
//            req_i         per-requester override request (held until done)
//            req_value_i   requester i value at [i*WIDTH +: WIDTH]
//            req_hold_i    requester i hold length at [i*CNTW +: CNTW]
//            grant_o       one-hot grant, high during FORCE
//            value_out_o   registered net value
//            forced_o      high while an override drives value_out_o
//            done_o        one-cycle pulse on a completed (non-aborted) override
// Revision : 1.0  initial release
// ============================================================================
module net_force_arbiter #(
  parameter int N     = 4,
  parameter int WIDTH = 4,
  parameter int CNTW  = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [WIDTH-1:0]     nominal_i,
  input  logic [N-1:0]         req_i,
  input  logic [N*WIDTH-1:0]   req_value_i,
  input  logic [N*CNTW-1:0]    req_hold_i,
  output logic [N-1:0]         grant_o,
  output logic [WIDTH-1:0]     value_out_o,
  output logic                 forced_o,
  output logic [N-1:0]         done_o
);

  localparam int IDXW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FORCE   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t            state_q;
  logic [IDXW-1:0]   rr_ptr_q;
  logic [IDXW-1:0]   idx_q;
  logic [WIDTH-1:0]  val_q;
  logic [CNTW-1:0]   cnt_q;
  logic [N-1:0]      grant_q;
  logic [WIDTH-1:0]  value_out_q;
  logic              forced_q;
  logic [N-1:0]      done_q;

  logic [IDXW:0]     sum_d;
  logic [IDXW-1:0]   sel_idx_d;
  logic [WIDTH-1:0]  sel_val_d;
  logic [CNTW-1:0]   sel_hold_d;
  logic [CNTW-1:0]   cnt_load_d;
  logic [IDXW-1:0]   rr_next_d;

  // Round-robin pick: scan offsets from the farthest to the nearest so the
  // first set bit at or after rr_ptr_q is the final assignment.
  always_comb begin
    sum_d      = '0;
    sel_idx_d  = '0;
    sel_val_d  = '0;
    sel_hold_d = '0;
    for (int off = N - 1; off >= 0; off--) begin
      sum_d = {1'b0, rr_ptr_q} + (IDXW+1)'(off);
      if (sum_d >= (IDXW+1)'(N)) begin
        sum_d = sum_d - (IDXW+1)'(N);
      end
      if (req_i[sum_d[IDXW-1:0]]) begin
        sel_idx_d = sum_d[IDXW-1:0];
      end
    end
    for (int i = 0; i < N; i++) begin
      if (sel_idx_d == IDXW'(i)) begin
        sel_val_d  = req_value_i[i*WIDTH +: WIDTH];
        sel_hold_d = req_hold_i[i*CNTW +: CNTW];
      end
    end
  end

  // A hold of zero behaves as a hold of one, so both load a count of zero.
  assign cnt_load_d = (sel_hold_d == '0) ? '0 : sel_hold_d - CNTW'(1);
  assign rr_next_d  = (idx_q == IDXW'(N - 1)) ? '0 : idx_q + IDXW'(1);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      idx_q       <= '0;
      val_q       <= '0;
      cnt_q       <= '0;
      grant_q     <= '0;
      value_out_q <= '0;
      forced_q    <= 1'b0;
      done_q      <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          done_q      <= '0;
          value_out_q <= nominal_i;
          if (|req_i) begin
            idx_q       <= sel_idx_d;
            val_q       <= sel_val_d;
            cnt_q       <= cnt_load_d;
            grant_q     <= N'(1) << sel_idx_d;
            forced_q    <= 1'b1;
            value_out_q <= sel_val_d;
            state_q     <= S_FORCE;
          end
        end
        S_FORCE: begin
          value_out_q <= val_q;
          if (!req_i[idx_q] || cnt_q == '0) begin
            // Abort (request dropped) takes priority and suppresses done.
            grant_q     <= '0;
            forced_q    <= 1'b0;
            value_out_q <= nominal_i;
            rr_ptr_q    <= rr_next_d;
            state_q     <= S_RELEASE;
            if (req_i[idx_q]) begin
              done_q <= N'(1) << idx_q;
            end
          end else begin
            cnt_q <= cnt_q - CNTW'(1);
          end
        end
        S_RELEASE: begin
          done_q      <= '0;
          value_out_q <= nominal_i;
          state_q     <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign grant_o     = grant_q;
  assign value_out_o = value_out_q;
  assign forced_o    = forced_q;
  assign done_o      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_net_force_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_net_force_arbiter
// Purpose  : Self-checking bench for net_force_arbiter. Directed scenarios
//            followed by randomized traffic, all compared cycle by cycle with
//            a schedule-based reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_net_force_arbiter;

  localparam int N     = 4;
  localparam int WIDTH = 4;
  localparam int CNTW  = 8;

  logic                clk;
  logic                reset;
  logic [WIDTH-1:0]    nominal;
  logic [N-1:0]        req;
  logic [N*WIDTH-1:0]  req_value;
  logic [N*CNTW-1:0]   req_hold;
  logic [N-1:0]        grant;
  logic [WIDTH-1:0]    value_out;
  logic                forced;
  logic [N-1:0]        done;

  int passed = 0;
  int total  = 0;

  net_force_arbiter #(.N(N), .WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .nominal_i   (nominal),
    .req_i       (req),
    .req_value_i (req_value),
    .req_hold_i  (req_hold),
    .grant_o     (grant),
    .value_out_o (value_out),
    .forced_o    (forced),
    .done_o      (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: an override is a window of cycle numbers
  // [f_start, f_end] followed by a single release cycle rel_cyc.
  int              cyc = 0;
  int              f_start = -10;
  int              f_end = -10;
  int              rel_cyc = -10;
  int              cur = 0;
  int              ptr = 0;
  bit              ab = 1'b0;
  logic [WIDTH-1:0] lval = '0;

  logic [WIDTH-1:0] e_val;
  logic [N-1:0]     e_grant;
  logic             e_forced;
  logic [N-1:0]     e_done;

  task automatic model_edge();
    int  n;
    int  h;
    bit  busy;
    bit  found;
    if (reset) begin
      ptr = 0; f_start = -10; f_end = -10; rel_cyc = -10; cur = 0; ab = 1'b0;
      e_val = '0; e_grant = '0; e_forced = 1'b0; e_done = '0;
    end else begin
      busy = (cyc >= f_start) && (cyc <= f_end);
      if (busy) begin
        if (!req[cur]) begin
          f_end = cyc; rel_cyc = cyc + 1; ab = 1'b1; ptr = (cur + 1) % N;
        end else if (cyc == f_end) begin
          ab = 1'b0; ptr = (cur + 1) % N;
        end
      end else if (cyc != rel_cyc && req != '0) begin
        found = 1'b0;
        for (int off = 0; off < N; off++) begin
          if (!found && req[(ptr + off) % N]) begin
            cur = (ptr + off) % N;
            found = 1'b1;
          end
        end
        lval = req_value[cur*WIDTH +: WIDTH];
        h = int'(req_hold[cur*CNTW +: CNTW]);
        if (h == 0) h = 1;
        f_start = cyc + 1; f_end = cyc + h; rel_cyc = cyc + h + 1; ab = 1'b0;
      end
      n = cyc + 1;
      e_forced = (n >= f_start) && (n <= f_end);
      e_grant  = e_forced ? N'(1 << cur) : '0;
      e_val    = e_forced ? lval : nominal;
      e_done   = (n == rel_cyc && !ab) ? N'(1 << cur) : '0;
    end
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("value_out", {4'b0, value_out}, {4'b0, e_val});
    chk("grant",     {4'b0, grant},     {4'b0, e_grant});
    chk("forced",    {7'b0, forced},    {7'b0, e_forced});
    chk("done",      {4'b0, done},      {4'b0, e_done});
    chk("forced_vs_grant", {7'b0, forced}, {7'b0, |grant});
  endtask

  logic [N-1:0] rr_exp [4];

  initial begin
    rr_exp = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
    reset = 1'b1; nominal = '0; req = '0; req_value = '0; req_hold = '0;
    step();
    chk("reset_value", {4'b0, value_out}, 8'h00);
    reset = 1'b0;
    step();

    // Single override, hold 3
    req_value[3:0] = 4'h5; req_hold[7:0] = 8'd3; req = 4'b0001;
    step();
    chk("single_f1", {4'b0, value_out}, 8'h05);
    step(); step();
    chk("single_f3", {7'b0, forced}, 8'h01);
    step();
    chk("single_rel_done", {4'b0, done}, 8'h01);
    chk("single_rel_val", {4'b0, value_out}, 8'h00);
    req = '0;
    step();

    // Round-robin from a fresh pointer
    reset = 1'b1; step(); reset = 1'b0;
    req_value = 16'h8021; req_hold = 32'h01010101; req = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr_grant", {4'b0, grant}, {4'b0, rr_exp[k]});
      step();
      chk("rr_gap1", {7'b0, forced}, 8'h00);
      step();
      chk("rr_gap2", {7'b0, forced}, 8'h00);
    end
    req = '0;
    step(); step();

    // Hold of zero
    req_hold[23:16] = 8'd0; req = 4'b0100;
    step();
    chk("h0_forced", {4'b0, grant}, 8'h04);
    step();
    chk("h0_done", {4'b0, done}, 8'h04);
    chk("h0_rel", {7'b0, forced}, 8'h00);
    req = '0;
    step();

    // Abort after 4 forced cycles
    req_hold[15:8] = 8'd10; req = 4'b0010;
    repeat (4) step();
    chk("abort_pre", {4'b0, grant}, 8'h02);
    req = 4'b0101;
    step();
    chk("abort_forced", {7'b0, forced}, 8'h00);
    chk("abort_nodone", {4'b0, done}, 8'h00);
    step();
    step();
    chk("abort_next", {4'b0, grant}, 8'h04);
    req = '0;
    step(); step(); step();

    // Reset during cycle 2 of a hold-5 override
    req_value[3:0] = 4'hA; req_hold[7:0] = 8'd5; req = 4'b0001;
    step(); step();
    reset = 1'b1;
    step();
    chk("rst_grant", {4'b0, grant}, 8'h00);
    chk("rst_value", {4'b0, value_out}, 8'h00);
    reset = 1'b0; req = '0; nominal = 4'h3;
    step();
    chk("rst_nom1", {4'b0, value_out}, 8'h03);
    nominal = 4'h6;
    step();
    chk("rst_nom2", {4'b0, value_out}, 8'h06);
    req = 4'b1001;
    step();
    chk("rst_rearb", {4'b0, grant}, 8'h01);
    req = '0;
    step(); step(); step();

    // Value latching during FORCE
    req_value[3:0] = 4'h5; req_hold[7:0] = 8'd4; req = 4'b0001;
    step();
    req_value[3:0] = 4'hC;
    repeat (3) begin
      step();
      chk("latch_val", {4'b0, value_out}, 8'h05);
    end
    step();
    chk("latch_rel", {4'b0, value_out}, {4'b0, nominal});
    req = '0;
    step();

    // Randomized traffic
    repeat (3000) begin
      nominal   = WIDTH'($urandom);
      req_value = (N*WIDTH)'($urandom);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
        req_hold[i*CNTW +: CNTW] = ($urandom_range(0, 99) == 0) ? 8'd40 : 8'($urandom_range(0, 5));
      end
      reset = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
